medium_matrix_transposer: RTL and testbench
===========================================

Name: medium_matrix_transposer

Overview:
- Downstream consumer of the row-major nibble stream produced by the shift-matrix stage.
- Collects one DIM x DIM frame of DATA_W-bit elements, arriving row-major on a valid/ready input.
- Re-emits each frame column-major, which is the transpose, on a valid/ready output.
- Ping-pong double buffering lets one frame fill while the previous frame drains.

Parameters:
- DATA_W, 4, element width in bits.
- DIM, 4, matrix dimension. Must be a power of two in the range 2..8. A frame is DIM*DIM elements.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream element valid
- in_data  input  DATA_W  upstream element, row-major order
- in_ready  output  1  block can accept an element this cycle
- out_valid  output  1  out_data holds a valid element
- out_data  output  DATA_W  transposed element, column-major order
- out_ready  input  1  downstream accepts the element
- out_last  output  1  marks the final element of the output frame

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces the following immediately, regardless of clk:
  - write row/col counters = 0, read row/col counters = 0
  - wr_bank = 0, rd_bank = 0, both bank-full flags = 0
  - in_ready = 1, out_valid = 0, out_last = 0, out_data = 0
- Storage is not reset. Contents are don't-care until written.
- Storage: two banks of DIM*DIM entries each. Entry address = row*DIM + col. Counters are log2(DIM) bits wide.
- Write side:
  - in_ready = !full[wr_bank] (combinational from registers).
  - On in_valid && in_ready: store in_data at bank[wr_bank][wr_row][wr_col]; wr_col += 1.
  - When wr_col == DIM-1: wr_col wraps to 0 and wr_row += 1.
  - On the element at (DIM-1, DIM-1): set full[wr_bank], toggle wr_bank, and both write counters wrap to 0.
  - If in_valid is high while in_ready is low, nothing is written and no state changes.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_row][rd_col]; out_data = 0 while out_valid = 0.
  - out_last = out_valid && rd_row == DIM-1 && rd_col == DIM-1.
  - On out_valid && out_ready: rd_row += 1.
  - When rd_row == DIM-1: rd_row wraps to 0 and rd_col += 1.
  - On the out_last transfer: clear full[rd_bank], toggle rd_bank, and both read counters wrap to 0.
- Latency: the last input element accepted at edge N gives out_valid = 1 after edge N, so the first output is available in cycle N+1 with zero bubble.
- Output stability: while out_valid && !out_ready, out_data and out_last hold stable.
- Throughput: one element per cycle in each direction when both banks cycle continuously.
- Simultaneous events:
  - A write-side frame completion and a read-side frame completion in the same cycle on different banks both take effect. The flag set and the flag clear are independent.
  - The block never writes into a bank whose full flag is set, so the write side cannot overrun the read side.
- Both banks full: in_ready = 0 until the read side finishes its current frame.
- Reset mid-frame: any partial input frame and any partially drained output frame are discarded. After release, the next accepted element is treated as row 0, col 0.

Optional Feature:
- Macro: MATRIX_TRANSPOSER_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt, 16 bits.
  - Reset value 0.
  - Increments by 1 on every out_last transfer and wraps from 0xFFFF to 0.
  - Adds output port overflow_seen, 1 bit, sticky. It is set when in_valid && !in_ready occurs, and is cleared only by rst_n.
- Undefined: neither port exists, and there is no counter logic.
- Core behaviour is identical in both builds.

Test Plan:
- DIM=4, out_ready=1. Stream inputs 0x0..0xF on consecutive cycles. Required:
  - outputs in order 0,4,8,C,1,5,9,D,2,6,A,E,3,7,B,F
  - out_last only on 0xF
  - first out_valid one cycle after 0xF is accepted
- Two back-to-back frames (0x0..0xF, then 0xF..0x0), out_ready=1. Required:
  - in_ready never drops
  - frame 2 output is F,B,7,3,E,A,6,2,D,9,5,1,C,8,4,0
  - frame 2 output begins the cycle after frame 1's out_last
- out_ready=0 while three frames are offered. Required:
  - in_ready drops after 32 accepted elements
  - out_data holds 0x0 stable
  - raising out_ready drains frame 1, then in_ready returns to 1
- out_ready toggles 1,0,1,0 during a drain. Required:
  - each element appears exactly once, in column-major order
  - out_last asserted only with element 0xF
- Assert rst_n low after 7 input elements and again in the middle of a drain. Required:
  - out_valid = 0 and in_ready = 1 asynchronously
  - after release, a fresh 0x0..0xF frame yields the first test's sequence
- With MATRIX_TRANSPOSER_FRAME_CNT_EN defined, run three frames with one stalled-input attempt. Required:
  - frame_cnt = 3
  - overflow_seen = 1
  - both return to 0 after rst_n

Source files
------------

// File: rtl/medium_matrix_transposer.sv
// Ping-pong frame transposer: row-major DIM x DIM frames in, column-major out.
// Optional macro MATRIX_TRANSPOSER_FRAME_CNT_EN adds frame_cnt and overflow_seen outputs.
module medium_matrix_transposer #(
  parameter int DATA_W = 4,
  parameter int DIM    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last
`ifdef MATRIX_TRANSPOSER_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic              overflow_seen
`endif
);

  localparam int AW    = $clog2(DIM);
  localparam int DEPTH = DIM * DIM;
  localparam logic [AW-1:0] LAST = AW'(DIM - 1);

  logic [AW-1:0]     wr_row, wr_col, rd_row, rd_col;
  logic              wr_bank, rd_bank;
  logic [1:0]        full;
  logic [DATA_W-1:0] mem [2][DEPTH];

  logic wr_fire, wr_done, rd_fire, rd_done;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_row == LAST) && (rd_col == LAST);
  assign out_data  = out_valid ? mem[rd_bank][{rd_row, rd_col}] : '0;

  assign wr_fire = in_valid && in_ready;
  assign wr_done = wr_fire && (wr_row == LAST) && (wr_col == LAST);
  assign rd_fire = out_valid && out_ready;
  assign rd_done = rd_fire && out_last;

  // Storage is intentionally unreset; a bank is only read after being fully written.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][{wr_row, wr_col}] <= in_data;
    end
  end

  // Counters wrap naturally because DIM is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_row  <= '0;
      wr_col  <= '0;
      wr_bank <= 1'b0;
    end else if (wr_fire) begin
      wr_col <= wr_col + 1'b1;
      if (wr_col == LAST) begin
        wr_row <= wr_row + 1'b1;
      end
      if (wr_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row  <= '0;
      rd_col  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_fire) begin
      rd_row <= rd_row + 1'b1;
      if (rd_row == LAST) begin
        rd_col <= rd_col + 1'b1;
      end
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

  // Set and clear always target different banks, so both may land in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      if (wr_done) begin
        full[wr_bank] <= 1'b1;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
      end
    end
  end

`ifdef MATRIX_TRANSPOSER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt     <= '0;
      overflow_seen <= 1'b0;
    end else begin
      if (rd_done) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (in_valid && !in_ready) begin
        overflow_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_medium_matrix_transposer.sv
// Directed self-checking bench for medium_matrix_transposer (DIM=4, DATA_W=4).
module tb_medium_matrix_transposer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  logic       out_last;
`ifdef MATRIX_TRANSPOSER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic        overflow_seen;
`endif

  int checks   = 0;
  int failures = 0;

  medium_matrix_transposer #(.DATA_W(4), .DIM(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef MATRIX_TRANSPOSER_FRAME_CNT_EN
    ,
    .frame_cnt     (frame_cnt),
    .overflow_seen (overflow_seen)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element stored at row-major index idx of an ascending or descending frame.
  function automatic logic [3:0] elemVal(input bit desc, input int idx);
    return desc ? 4'(15 - idx) : 4'(idx);
  endfunction

  // Row-major index of the k-th column-major output element.
  function automatic int colMajorIdx(input int k);
    return (k % 4) * 4 + (k / 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Stream nframes back to back (ascending, descending, ...) with out_ready high.
  task automatic streamFrames(input int nframes);
    for (int t = 0; t < 16 * (nframes + 1); t++) begin
      if (t < 16 * nframes) applyStimulus(1'b1, elemVal(((t / 16) % 2) == 1, t % 16), 1'b1);
      else                  applyStimulus(1'b0, 4'h0, 1'b1);
      if (t < 16 * nframes) checkOutput("stream_in_ready", in_ready, 1);
      if (t < 16) begin
        checkOutput("stream_no_valid", out_valid, 0);
      end else begin
        checkOutput("stream_valid", out_valid, 1);
        checkOutput("stream_data", out_data,
                    elemVal((((t - 16) / 16) % 2) == 1, colMajorIdx((t - 16) % 16)));
        checkOutput("stream_last", out_last, ((t - 16) % 16) == 15);
      end
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("stream_idle", out_valid, 0);
  endtask

  initial begin
    int k;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    #2;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single frame transpose");
    streamFrames(1);

    $display("[TB] two back-to-back frames");
    streamFrames(2);

    $display("[TB] stalled output, three frames offered");
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'b1, elemVal(((t / 16) % 2) == 1, t % 16), 1'b0);
      checkOutput("stall_in_ready", in_ready, t < 32);
      checkOutput("stall_valid", out_valid, t >= 16);
      if (t >= 16) begin
        checkOutput("stall_data_hold", out_data, 0);
        checkOutput("stall_last", out_last, 0);
      end
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("drain1_in_ready", in_ready, 0);
      checkOutput("drain1_data", out_data, elemVal(1'b0, colMajorIdx(i)));
      checkOutput("drain1_last", out_last, i == 15);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("drain2_in_ready", in_ready, 1);
      checkOutput("drain2_valid", out_valid, 1);
      checkOutput("drain2_data", out_data, elemVal(1'b1, colMajorIdx(i)));
    end
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("drain2_idle", out_valid, 0);

    $display("[TB] toggling out_ready");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'(i), 1'b0);
    k = 0;
    for (int t = 0; t < 40 && k < 16; t++) begin
      applyStimulus(1'b0, 4'h0, (t % 2) == 0);
      checkOutput("toggle_valid", out_valid, 1);
      checkOutput("toggle_data", out_data, elemVal(1'b0, colMajorIdx(k)));
      checkOutput("toggle_last", out_last, k == 15);
      if (out_ready) k++;
    end
    checkOutput("toggle_count", k, 16);
    applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("toggle_idle", out_valid, 0);

    $display("[TB] reset after partial input frame");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'(i + 3), 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_part_valid", out_valid, 0);
    checkOutput("rst_part_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    streamFrames(1);

    $display("[TB] reset in the middle of a drain");
    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 4'(15 - (i % 16)), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 1'b1);
    checkOutput("pre_rst_valid", out_valid, 1);
    checkOutput("pre_rst_in_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_drain_valid", out_valid, 0);
    checkOutput("rst_drain_in_ready", in_ready, 1);
    checkOutput("rst_drain_data", out_data, 0);
    checkOutput("rst_drain_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    streamFrames(1);

`ifdef MATRIX_TRANSPOSER_FRAME_CNT_EN
    $display("[TB] frame counter and overflow flag");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("cnt_reset", frame_cnt, 0);
    checkOutput("ovf_reset", overflow_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
    streamFrames(3);
    checkOutput("cnt_three", frame_cnt, 3);
    checkOutput("ovf_clear", overflow_seen, 0);
    for (int i = 0; i < 33; i++) applyStimulus(1'b1, 4'(i % 16), 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("ovf_set", overflow_seen, 1);
    checkOutput("cnt_hold", frame_cnt, 3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("cnt_after_rst", frame_cnt, 0);
    checkOutput("ovf_after_rst", overflow_seen, 0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
